// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_ctrl
// Purpose  : Run/stop sequencer for a cascaded chain of decade digit counters.
//            A prescaler turns clk into count ticks while running. The ticks
//            drive a ripple-carry chain of mod-10 digits. Start/stop/clear are
//            handled by a four-state FSM. Lap snapshots of the count and a
//            sticky terminal-count flag are also provided.
// Ports    : clk, rst       - clock / asynchronous active-high reset
//            start, stop    - level commands: enter RUN / pause RUN
//            clear          - zero everything, return to IDLE
//            lap            - snapshot the live count into lap_bcd
//            bcd            - live packed BCD count (digit 0 in [3:0])
//            lap_bcd        - last snapshot
//            lap_valid      - one-cycle pulse after each snapshot
//            running        - high while in RUN
//            overflow       - sticky terminal-count flag
// Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int WRAP     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [4*DIGITS-1:0]   lap_bcd,
    output logic                  lap_valid,
    output logic                  running,
    output logic                  overflow
);

    localparam int            BW      = 4 * DIGITS;
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_OVERFLOW = 2'd3
    } state_t;

    state_t         state_q,     state_d;
    logic [PW-1:0]  presc_q,     presc_d;
    logic [BW-1:0]  bcd_q,       bcd_d;
    logic [BW-1:0]  lap_bcd_q,   lap_bcd_d;
    logic           lap_valid_q, lap_valid_d;
    logic           running_q,   running_d;
    logic           overflow_q,  overflow_d;

    logic           count_en;
    logic           tick;
    logic           terminal;
    logic [DIGITS:0] carry;      // carry[i] = increment request into digit i
    logic [BW-1:0]  bcd_adv;     // chain value after one tick

    // Counting happens only in RUN on edges where neither clear nor stop
    // alters the state; start in RUN is a no-op and does not block counting.
    assign count_en = (state_q == ST_RUN) && !clear && !stop;
    assign tick     = count_en && (presc_q == PS_LAST);
    assign carry[0] = tick;
    assign terminal = carry[DIGITS];   // every digit was 9 on a tick

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [3:0] cur;
            logic       nine;
            assign cur          = bcd_q[4*g +: 4];
            assign nine         = (cur == 4'd9);
            assign carry[g+1]   = carry[g] & nine;
            assign bcd_adv[4*g +: 4] = !carry[g] ? cur :
                                       nine      ? 4'd0 : (cur + 4'd1);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        bcd_d       = bcd_q;
        lap_bcd_d   = lap_bcd_q;
        lap_valid_d = 1'b0;
        overflow_d  = overflow_q;

        // Snapshot uses the pre-update count; clear below overrides it.
        if (lap && (state_q != ST_IDLE)) begin
            lap_bcd_d   = bcd_q;
            lap_valid_d = 1'b1;
        end

        if (clear) begin
            state_d     = ST_IDLE;
            presc_d     = '0;
            bcd_d       = '0;
            lap_bcd_d   = '0;
            lap_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else if (stop) begin
            // stop outranks start in every state, even where stop is a no-op
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start) begin
            if ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) begin
                state_d = ST_RUN;
            end
        end

        if (count_en) begin
            presc_d = tick ? '0 : (presc_q + PW'(1));
            if (terminal) begin
                overflow_d = 1'b1;
                if (WRAP != 0) begin
                    bcd_d = bcd_adv;          // all digits rolled to 0
                end else begin
                    state_d = ST_OVERFLOW;    // hold at all nines
                end
            end else begin
                bcd_d = bcd_adv;
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            bcd_q       <= '0;
            lap_bcd_q   <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            bcd_q       <= bcd_d;
            lap_bcd_q   <= lap_bcd_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bcd       = bcd_q;
    assign lap_bcd   = lap_bcd_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_stopwatch_ctrl
// Purpose  : Scoreboard bench for bcd_stopwatch_ctrl. Two instances share the
//            command inputs: A (2 digits, prescale 4, halt at terminal) and
//            B (2 digits, prescale 1, wrap at terminal). A count-as-integer
//            reference model predicts each edge; a monitor compares on negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUS = 2;
    localparam int M_OVF  = 3;

    typedef struct {
        logic [7:0] bcd;
        logic [7:0] lap;
        logic       lv;
        logic       run;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

    logic [7:0] bcd_a, lap_a, bcd_b, lap_b;
    logic       lv_a, run_a, ov_a, lv_b, run_b, ov_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // reference model state, per instance
    int m_cnt[2], m_ps[2], m_st[2], m_lap[2];
    bit m_ov[2], m_lv[2];

    bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(4), .WRAP(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .bcd(bcd_a), .lap_bcd(lap_a), .lap_valid(lv_a),
        .running(run_a), .overflow(ov_a)
    );

    bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(1), .WRAP(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .bcd(bcd_b), .lap_bcd(lap_b), .lap_valid(lv_b),
        .running(run_b), .overflow(ov_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_st[i] = M_IDLE;
            m_lap[i] = 0; m_ov[i] = 1'b0; m_lv[i] = 1'b0;
        end
    endfunction

    // One clock edge of the stopwatch, from the behavioural rules.
    function automatic void model_step(input int i);
        int p;
        bit w;
        p = (i == 0) ? 4 : 1;
        w = (i == 1);
        m_lv[i] = 1'b0;
        if (lap && !clear && m_st[i] != M_IDLE) begin
            m_lap[i] = m_cnt[i];
            m_lv[i]  = 1'b1;
        end
        if (clear) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_ov[i] = 1'b0;
            m_lap[i] = 0; m_lv[i] = 1'b0; m_st[i] = M_IDLE;
        end else if (stop && m_st[i] == M_RUN) begin
            m_st[i] = M_PAUS;
        end else if (!stop && start && (m_st[i] == M_IDLE || m_st[i] == M_PAUS)) begin
            m_st[i] = M_RUN;
        end else if (!stop && m_st[i] == M_RUN) begin
            m_ps[i]++;
            if (m_ps[i] == p) begin
                m_ps[i] = 0;
                if (m_cnt[i] == 99) begin
                    m_ov[i] = 1'b1;
                    if (w) m_cnt[i] = 0;
                    else   m_st[i]  = M_OVF;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t e;
        e.bcd = to_bcd(m_cnt[i]);
        e.lap = to_bcd(m_lap[i]);
        e.lv  = m_lv[i];
        e.run = (m_st[i] == M_RUN);
        e.ov  = m_ov[i];
        return e;
    endfunction

    function automatic void check(input string nm, input exp_t e,
                                  input logic [7:0] b, input logic [7:0] lb,
                                  input logic lv, input logic r, input logic o);
        n_checks++;
        if (b !== e.bcd || lb !== e.lap || lv !== e.lv || r !== e.run || o !== e.ov) begin
            n_fail++;
            $display("FAIL %s @%0t: got bcd=%h lap=%h lv=%b run=%b ov=%b, expected bcd=%h lap=%h lv=%b run=%b ov=%b",
                     nm, $time, b, lb, lv, r, o, e.bcd, e.lap, e.lv, e.run, e.ov);
        end
    endfunction

    // Monitor: every posedge produces one expected record per instance.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("dut_a", e, bcd_a, lap_a, lv_a, run_a, ov_a);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("dut_b", e, bcd_b, lap_b, lv_b, run_b, ov_b);
        end
    end

    task automatic cycle(input bit c, input bit sp, input bit st, input bit l);
        @(negedge clk);
        #1;
        clear = c; stop = sp; start = st; lap = l;
        model_step(0);
        model_step(1);
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic async_reset();
        exp_t z;
        @(negedge clk);
        #2;
        clear = 1'b0; stop = 1'b0; start = 1'b0; lap = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        z = model_out(0);
        check("rst_a", z, bcd_a, lap_a, lv_a, run_a, ov_a);
        z = model_out(1);
        check("rst_b", z, bcd_b, lap_b, lv_b, run_b, ov_b);
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 begin
            exp_t z;
            z = model_out(0);
            check("por_a", z, bcd_a, lap_a, lv_a, run_a, ov_a);
            z = model_out(1);
            check("por_b", z, bcd_b, lap_b, lv_b, run_b, ov_b);
        end
        #10 rst = 1'b0;

        idle(20);                               // quiet after reset
        cycle(0, 0, 1, 0);                      // start
        idle(3);                                // A prescaler reaches 3
        cycle(0, 1, 0, 0);                      // stop on would-be tick edge
        idle(10);                               // paused: count frozen
        cycle(0, 0, 1, 0);                      // resume
        idle(25);
        cycle(0, 1, 0, 1);                      // stop + lap
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1);   // held lap in PAUSED
        cycle(0, 0, 1, 0);                      // resume
        idle(1700);                             // A reaches overflow, B wraps
        cycle(0, 0, 1, 0);                      // start ignored in OVERFLOW
        cycle(0, 0, 0, 1);                      // lap in OVERFLOW / RUN
        idle(2);
        cycle(1, 0, 0, 1);                      // lap + clear
        idle(3);
        cycle(0, 0, 0, 1);                      // lap in IDLE ignored
        cycle(0, 1, 1, 0);                      // start + stop in IDLE
        idle(2);
        cycle(0, 0, 1, 0);
        idle(50);
        cycle(0, 1, 1, 0);                      // start + stop in RUN
        cycle(0, 0, 1, 0);
        idle(17);
        async_reset();                          // mid-run reset
        idle(5);

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7)  == 0),
                  ($urandom_range(0, 7)  == 0));
        end
        idle(2);
        @(negedge clk);
        #2;
        clear = 1'b0; stop = 1'b0; start = 1'b0; lap = 1'b0;

        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending a=%0d b=%0d, expected 0 0", q_a.size(), q_b.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Run/stop controller for a cascaded chain of decade (mod-10) digit counters, used as the sequencing layer above the team's decade counter primitives. It owns a clock prescaler that generates count ticks, gates and cascades the digit chain, handles start/stop/clear/lap commands through a small state machine, and flags terminal-count overflow. Digit outputs are packed BCD, least-significant digit in bits [3:0], for display drivers downstream.

## Interface
- DIGITS, 4: number of cascaded decade digits; legal range 1..8.
- PRESCALE, 10: clk cycles per count tick; legal range ≥1.
- WRAP, 0: behaviour at terminal count. 0 = halt in OVERFLOW. 1 = wrap to zero and keep running.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level-sampled command: enter RUN from IDLE or PAUSED.
- stop  in  1  level-sampled command: RUN → PAUSED.
- clear  in  1  level-sampled command: zero everything and return to IDLE.
- lap  in  1  level-sampled command: capture current count.
- bcd  out  4*DIGITS  live count, packed BCD.
- lap_bcd  out  4*DIGITS  last captured count.
- lap_valid  out  1  one-cycle pulse when lap_bcd updates.
- running  out  1  high while state is RUN.
- overflow  out  1  sticky terminal-count flag.

## Operation
- States: IDLE, RUN, PAUSED, OVERFLOW.
- Reset values: state IDLE, bcd 0, lap_bcd 0, lap_valid 0, running 0, overflow 0, prescaler 0.
- Command priority per edge is clear > stop > start. Exactly one command takes effect.
  - clear (any state): digits, prescaler, overflow, lap_bcd and lap_valid go to 0; state goes to IDLE.
  - stop: RUN → PAUSED. Ignored in other states.
  - start: IDLE or PAUSED → RUN. Ignored in RUN and OVERFLOW.
- OVERFLOW is left only by clear or rst.
- Prescaler:
  - Counts 0..PRESCALE-1 only on edges where state is RUN and no command changes state on that edge.
  - tick = (prescaler == PRESCALE-1) on a counting edge; the prescaler wraps to 0 on that edge.
  - The prescaler holds its value in PAUSED, so a resume continues the partial period. It is zeroed by clear.
- Digit chain:
  - Digit i increments on tick when all digits below i equal 9.
  - A digit at 9 that increments wraps to 0.
  - Digits never hold values above 9.
- Terminal count (all digits 9 and tick):
  - WRAP=0: digits hold at all 9s, state → OVERFLOW, overflow ← 1.
  - WRAP=1: digits → all 0, overflow ← 1 (sticky), state stays RUN.
- Lap:
  - When lap is high in RUN, PAUSED or OVERFLOW, and clear is low, lap_bcd ← bcd value before the edge's update.
  - lap_valid is high for the following cycle only.
  - lap in IDLE is ignored.
  - lap held high recaptures every cycle.

## Timing
- running and bcd are registered outputs, with no combinational paths from inputs.
- start sampled at edge E0 → running=1 after E0. The first bcd increment occurs at edge E0+PRESCALE.
- stop sampled at edge E with the prescaler at PRESCALE-1 → no tick on E. The pending tick fires PRESCALE-(stored value) edges after resume… i.e., on the first counting edge after the next start.
- PRESCALE=1: one tick on every counting edge.
- Simultaneous events:
  - start+stop in RUN → PAUSED.
  - start+stop in IDLE → stays IDLE (stop wins; no state change).
  - lap+clear → clear only, lap_valid 0.
  - lap on a tick edge captures the pre-increment value.
- rst mid-run returns all outputs to reset values immediately (asynchronous). The first edge after rst deassertion is treated as an IDLE-state edge.

## Test plan
- Reset, then idle 20 cycles with no commands → bcd=0, running=0, overflow=0, lap_valid=0 throughout.
- DIGITS=2, PRESCALE=2: pulse start, wait 20 cycles → bcd=0x10. The 0x09→0x10 carry lands on the 20th edge after the start edge.
- PRESCALE=4: start, stop at prescaler=3, wait 10 cycles, start → bcd unchanged while PAUSED; first increment on the first edge after resume.
- DIGITS=2, WRAP=0: run to 0x99, then one more tick → bcd holds 0x99, overflow=1, running=0. A start pulse is ignored; clear → bcd=0, overflow=0, IDLE.
- DIGITS=2, WRAP=1: 0x99 + tick → bcd=0x00, overflow=1, running=1. Counting continues to 0x01.
- lap at bcd=0x37 on a tick edge → lap_bcd=0x37 and a single-cycle lap_valid. lap+clear together → lap_bcd=0, lap_valid=0. rst asserted mid-count → all outputs 0 asynchronously.
